// File: rtl/fifo_spram_port_ctrl_pkg.sv
// Shared types and default widths for the single-port-RAM FIFO port controller.
package fifo_spram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // Output-stage state: what the show-ahead register currently holds
  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FETCH = 2'd1,
    OUT_HOLD  = 2'd2
  } out_state_e;

endpackage

// File: rtl/fifo_spram_port_ctrl_if.sv
// Push/pop handshakes, address-unit hooks and RAM port of the FIFO port controller.
interface fifo_spram_port_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              pop_ready;
  logic              au_empty;
  logic              au_full;
  logic [ADDR_W-1:0] au_r_adr;
  logic [ADDR_W-1:0] au_w_adr;
  logic              au_re;
  logic              au_we;
  logic              mem_cs;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Controller side
  modport slave (
    input  push_valid, push_data, pop_ready,
    input  au_empty, au_full, au_r_adr, au_w_adr, mem_rdata,
    output push_ready, pop_valid, pop_data,
    output au_re, au_we, mem_cs, mem_wen, mem_addr, mem_wdata
  );

  // Environment side: producer, consumer, address unit and RAM
  modport master (
    output push_valid, push_data, pop_ready,
    output au_empty, au_full, au_r_adr, au_w_adr, mem_rdata,
    input  push_ready, pop_valid, pop_data,
    input  au_re, au_we, mem_cs, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fifo_spram_port_ctrl_out_stage.sv
// Show-ahead output stage: tracks the head word from RAM read to pop.
module fifo_out_stage
  import fifo_spram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_grant,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pop_ready,
  output logic              need_fill,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data
);

  out_state_e state_q;
  out_state_e state_d;

  assign pop_valid = (state_q == OUT_HOLD);
  // The register wants a new word when empty or when its word leaves this cycle
  assign need_fill = (state_q == OUT_EMPTY) | (pop_valid & pop_ready);

  // State register; reset drops any held word and any read in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  // Next state: a granted read always lands one cycle later
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (rd_grant) state_d = OUT_FETCH;
      OUT_FETCH: state_d = OUT_HOLD;
      OUT_HOLD: begin
        // A pop without a grant means the RAM was empty
        if (pop_ready) state_d = rd_grant ? OUT_FETCH : OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Head-word register: loads RAM data in the cycle after the read access
  always_ff @(posedge clk) begin
    if (rst)                       pop_data <= '0;
    else if (state_q == OUT_FETCH) pop_data <= mem_rdata;
  end

endmodule

// File: rtl/fifo_spram_port_ctrl.sv
// Arbitrates the single RAM port between pushes and head refills, and
// drives the address unit's pointer-advance strobes.
module fifo_spram_port_ctrl
  import fifo_spram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  fifo_spram_port_ctrl_if.slave bus
);

  logic need_fill;
  logic rd_grant;
  logic wr_grant;

  // Grant logic and port muxing; refill reads win so the head never starves
  always_comb begin
    rd_grant       = ~rst & need_fill & ~bus.au_empty;
    bus.push_ready = ~rst & ~bus.au_full & ~rd_grant;
    wr_grant       = bus.push_valid & bus.push_ready;
    bus.au_re      = rd_grant;
    bus.au_we      = wr_grant;
    bus.mem_cs     = rd_grant | wr_grant;
    bus.mem_wen    = wr_grant;
    bus.mem_addr   = wr_grant ? bus.au_w_adr : bus.au_r_adr;
    bus.mem_wdata  = bus.push_data;
  end

  fifo_out_stage #(.DATA_W(DATA_W)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .rd_grant  (rd_grant),
    .mem_rdata (bus.mem_rdata),
    .pop_ready (bus.pop_ready),
    .need_fill (need_fill),
    .pop_valid (bus.pop_valid),
    .pop_data  (bus.pop_data)
  );

endmodule

// File: tb/tb_fifo_spram_port_ctrl.sv
// Bench for the FIFO port controller: behavioural address unit and RAM,
// queue-based FIFO reference model, random and directed stimulus.
module tb_fifo_spram_port_ctrl;
  import fifo_spram_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CAP    = DEPTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_spram_port_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_spram_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Address unit: wrapping pointers and an occupancy count
  logic [ADDR_W-1:0] r_adr, w_adr;
  int level;
  always @(posedge clk) begin
    if (rst) begin
      r_adr <= '0; w_adr <= '0; level <= 0;
    end else begin
      if (bus.au_re) r_adr <= r_adr + 1'b1;
      if (bus.au_we) w_adr <= w_adr + 1'b1;
      level <= level + int'(bus.au_we) - int'(bus.au_re);
    end
  end
  assign bus.au_empty = (level == 0);
  assign bus.au_full  = (level == DEPTH);
  assign bus.au_r_adr = r_adr;
  assign bus.au_w_adr = w_adr;

  // Single-port RAM with one-cycle read latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
      else             bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: words leave in exactly the order they were accepted
  logic [DATA_W-1:0] q [$];
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_w;
    if (rst) begin
      q.delete();
      check("rst_comb_outs", 32'({bus.push_ready, bus.au_re, bus.au_we, bus.mem_cs}), 32'(0));
    end else begin
      if (bus.pop_valid && bus.pop_ready) begin
        if (q.size() == 0) check("pop_extra_word", 32'(bus.pop_valid), 32'(0));
        else begin
          exp_w = q.pop_front();
          check("pop_data", 32'(bus.pop_data), 32'(exp_w));
        end
      end
      if (bus.push_valid && bus.push_ready) begin
        q.push_back(bus.push_data);
        check("capacity", 32'(q.size() <= CAP), 32'(1));
      end
    end
    check("mem_cs", 32'(bus.mem_cs), 32'(bus.au_re | bus.au_we));
    if (bus.au_re || bus.au_we) check("re_we_excl", 32'(bus.au_re & bus.au_we), 32'(0));
    if (bus.au_re) begin
      check("rd_addr", 32'(bus.mem_addr), 32'(r_adr));
      check("rd_wen", 32'(bus.mem_wen), 32'(0));
    end
    if (bus.au_we) begin
      check("wr_addr", 32'(bus.mem_addr), 32'(w_adr));
      check("wr_wen", 32'(bus.mem_wen), 32'(1));
      check("wr_data", 32'(bus.mem_wdata), 32'(bus.push_data));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    bit done = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      sample();
      done = bus.push_ready;
      tick();
    end
    bus.push_valid = 1'b0;
    check("push_accepted", 32'(done), 32'(1));
  endtask

  task automatic pop_word();
    bit done = 1'b0;
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      sample();
      done = bus.pop_valid;
      tick();
    end
    bus.pop_ready = 1'b0;
    check("pop_taken", 32'(done), 32'(1));
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      sample();
      done = (q.size() == 0) && !bus.pop_valid;
      tick();
    end
    bus.pop_ready = 1'b0;
    check(tag, 32'(done), 32'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] held;
    bit acc;
    bit seen;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;

    // 1: reset state, then single-word latency
    rst = 1'b1;
    repeat (2) tick();
    sample();
    check("rst_pop_valid", 32'(bus.pop_valid), 32'(0));
    check("rst_push_ready", 32'(bus.push_ready), 32'(0));
    tick();
    rst = 1'b0;
    sample();
    check("post_rst_pop_valid", 32'(bus.pop_valid), 32'(0));
    check("post_rst_pop_data", 32'(bus.pop_data), 32'(0));
    check("post_rst_push_ready", 32'(bus.push_ready), 32'(1));
    tick();
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hA5;
    sample();
    check("t1_we_n", 32'({bus.au_we, bus.mem_cs, bus.mem_wen}), 32'(3'b111));
    tick();
    bus.push_valid = 1'b0;
    sample();
    check("t1_re_n1", 32'({bus.au_re, bus.mem_cs, bus.mem_wen}), 32'(3'b110));
    tick();
    sample();
    check("t1_pop_valid_n2", 32'(bus.pop_valid), 32'(0));
    tick();
    sample();
    check("t1_pop_valid_n3", 32'(bus.pop_valid), 32'(1));
    check("t1_pop_data_n3", 32'(bus.pop_data), 32'(8'hA5));
    tick();
    pop_word();
    drain("t1_drained");

    // 2: fill to capacity with pop_ready low
    for (int i = 1; i <= CAP; i++) push_word(DATA_W'(i));
    repeat (3) tick();
    sample();
    check("t2_push_ready", 32'(bus.push_ready), 32'(0));
    check("t2_au_full", 32'(bus.au_full), 32'(1));
    check("t2_pop_valid", 32'(bus.pop_valid), 32'(1));
    check("t2_head", 32'(bus.pop_data), 32'(1));
    check("t2_model_level", 32'(q.size()), 32'(CAP));
    tick();

    // 3: from full, pop and push continuously
    bus.pop_ready  = 1'b1;
    bus.push_valid = 1'b1;
    d = 8'h0A;
    bus.push_data = d;
    for (int i = 0; i < 60; i++) begin
      sample();
      acc = bus.push_ready;
      tick();
      if (acc) begin
        d = d + 1'b1;
        bus.push_data = d;
      end
    end
    bus.push_valid = 1'b0;
    drain("t3_drained");

    // 4: pointer wrap with random data, refilling between pop bursts
    for (int i = 0; i < CAP; i++) push_word(DATA_W'($urandom_range(0, 255)));
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        pop_word();
        repeat ($urandom_range(0, 2)) tick();
      end
      for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom_range(0, 255)));
      for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom_range(0, 255)));
    end
    drain("t4_drained");

    // 5: reset while a refill read is in flight with 4 words in RAM
    for (int i = 0; i < 6; i++) push_word(DATA_W'(8'h50 + i));
    repeat (3) tick();
    bus.pop_ready = 1'b1;
    sample();
    check("t5_hold_before_pop", 32'(bus.pop_valid), 32'(1));
    tick();
    bus.pop_ready = 1'b0;
    rst = 1'b1;
    sample();
    check("t5_fetch_pop_valid", 32'(bus.pop_valid), 32'(0));
    check("t5_ram_level", 32'(level), 32'(4));
    tick();
    rst = 1'b0;
    sample();
    check("t5_after_rst_pop_valid", 32'(bus.pop_valid), 32'(0));
    check("t5_after_rst_pop_data", 32'(bus.pop_data), 32'(0));
    tick();
    push_word(8'h3C);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      seen = bus.pop_valid;
      tick();
    end
    sample();
    check("t5_new_head_valid", 32'(bus.pop_valid), 32'(1));
    check("t5_new_head_data", 32'(bus.pop_data), 32'(8'h3C));
    tick();
    drain("t5_drained");

    // 6: stalled consumer with random pushes behind it
    for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom_range(0, 255)));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sample();
      seen = bus.pop_valid;
      tick();
    end
    sample();
    held = bus.pop_data;
    check("t6_head_is_oldest", 32'(held), 32'(q[0]));
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.push_valid = 1'($urandom_range(0, 1));
      bus.push_data  = DATA_W'($urandom_range(0, 255));
      sample();
      check("t6_pop_valid", 32'(bus.pop_valid), 32'(1));
      check("t6_pop_data_stable", 32'(bus.pop_data), 32'(held));
      check("t6_no_read", 32'(bus.au_re), 32'(0));
      tick();
    end
    bus.push_valid = 1'b0;
    drain("t6_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
